// File: rtl/led_scan_pkg.sv
// Shared types, default timing constants and width helpers for the LED row-scan scheduler.
package led_scan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BLANK  = 2'd1,
      SETTLE = 2'd2,
      ON     = 2'd3
   } scan_state_t;

   localparam int unsigned ROW_W_DEF         = 6;
   localparam int unsigned BLANK_CYCLES_DEF  = 4;
   localparam int unsigned SETTLE_CYCLES_DEF = 2;
   localparam int unsigned ON_MULT_DEF       = 4;
   localparam int unsigned WDOG_CYCLES_DEF   = 65535;

   // Width that holds 255*on_mult without truncation.
   function automatic int unsigned on_timer_w(input int unsigned on_mult);
      return 32'd8 + 32'($clog2(on_mult));
   endfunction

   // Shared timer must also hold the BLANK and SETTLE load values.
   function automatic int unsigned timer_w(input int unsigned blank_cycles,
                                           input int unsigned settle_cycles,
                                           input int unsigned on_mult);
      int unsigned w;
      w = on_timer_w(on_mult);
      if (32'($clog2(blank_cycles + 32'd1)) > w)  w = 32'($clog2(blank_cycles + 32'd1));
      if (32'($clog2(settle_cycles + 32'd1)) > w) w = 32'($clog2(settle_cycles + 32'd1));
      return w;
   endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Loadable down-counter shared by the BLANK, SETTLE and ON phases; expired_c marks the last cycle.
module led_scan_timer #(
   parameter int unsigned W = 10
) (
   input  logic         i2s_clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired_c
);

   logic [W-1:0] count;

   always_ff @(posedge i2s_clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   // A load of V keeps the phase alive for exactly V cycles.
   assign expired_c = (count == W'(1));

endmodule

// File: rtl/led_scan_ctrl.sv
// LED panel row-scan scheduler: blank, change row, settle, then light for brightness*ON_MULT cycles.
// Optional watchdog stall enabled by defining LED_SCAN_WATCHDOG_EN.
module led_scan_ctrl
   import led_scan_pkg::*;
#(
   parameter int unsigned ROW_W         = ROW_W_DEF,
   parameter int unsigned BLANK_CYCLES  = BLANK_CYCLES_DEF,
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int unsigned ON_MULT       = ON_MULT_DEF,
   parameter int unsigned WDOG_CYCLES   = WDOG_CYCLES_DEF
) (
   input  logic             i2s_clk,
   input  logic             rst,
   input  logic             lat_in,
   input  logic [ROW_W-1:0] row_in,
   input  logic [7:0]       brightness,
   output logic [ROW_W-1:0] row_addr,
   output logic             led_oe,
   output logic             busy,
   output logic             frame_start,
   output logic             overrun,
   output logic             stall
);

   localparam int unsigned TW = timer_w(BLANK_CYCLES, SETTLE_CYCLES, ON_MULT);

   scan_state_t      state, state_nxt;
   logic [ROW_W-1:0] cap_row, cap_row_nxt, row_addr_nxt;
   logic [7:0]       cap_bri, cap_bri_nxt;
   logic             led_oe_nxt, busy_nxt, frame_start_nxt, overrun_nxt;
   logic             tmr_load_c, tmr_expired_c, wdog_trip_c;
   logic [TW-1:0]    tmr_val_c;

   led_scan_timer #(.W(TW)) u_timer (
      .i2s_clk   (i2s_clk),
      .rst       (rst),
      .load      (tmr_load_c),
      .load_val  (tmr_val_c),
      .expired_c (tmr_expired_c)
   );

`ifdef LED_SCAN_WATCHDOG_EN
   localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wdog_cnt;

   // Trip on the cycle the counter reaches WDOG_CYCLES, then hold until a latch.
   assign wdog_trip_c = !lat_in && (stall || (wdog_cnt == WW'(WDOG_CYCLES - 1)));

   always_ff @(posedge i2s_clk) begin
      if (rst) begin
         wdog_cnt <= '0;
         stall    <= 1'b0;
      end else begin
         stall <= wdog_trip_c;
         if (lat_in) begin
            wdog_cnt <= '0;
         end else if (wdog_cnt != WW'(WDOG_CYCLES)) begin
            wdog_cnt <= wdog_cnt + WW'(1);
         end
      end
   end
`else
   logic unused_wdog;
   assign unused_wdog = ^WDOG_CYCLES;
   assign wdog_trip_c = 1'b0;
   assign stall       = 1'b0;
`endif

   // State register.
   always_ff @(posedge i2s_clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state, timer control and next registered outputs; a new latch always wins.
   always_comb begin
      state_nxt       = state;
      cap_row_nxt     = cap_row;
      cap_bri_nxt     = cap_bri;
      row_addr_nxt    = row_addr;
      led_oe_nxt      = led_oe;
      frame_start_nxt = 1'b0;
      overrun_nxt     = 1'b0;
      tmr_load_c      = 1'b0;
      tmr_val_c       = '0;

      if (lat_in) begin
         cap_row_nxt     = row_in;
         cap_bri_nxt     = brightness;
         tmr_load_c      = 1'b1;
         tmr_val_c       = TW'(BLANK_CYCLES);
         state_nxt       = BLANK;
         led_oe_nxt      = 1'b1;
         frame_start_nxt = (row_in == '0);
         overrun_nxt     = (state == SETTLE) || (state == ON);
      end else begin
         case (state)
            BLANK: begin
               if (tmr_expired_c) begin
                  row_addr_nxt = cap_row;
                  tmr_load_c   = 1'b1;
                  tmr_val_c    = TW'(SETTLE_CYCLES);
                  state_nxt    = SETTLE;
               end
            end
            SETTLE: begin
               if (tmr_expired_c) begin
                  if (cap_bri == 8'd0) begin
                     state_nxt  = IDLE;
                     led_oe_nxt = 1'b1;
                  end else begin
                     tmr_load_c = 1'b1;
                     tmr_val_c  = TW'(cap_bri) * TW'(ON_MULT);
                     state_nxt  = ON;
                     led_oe_nxt = 1'b0;
                  end
               end
            end
            ON: begin
               if (tmr_expired_c) begin
                  state_nxt  = IDLE;
                  led_oe_nxt = 1'b1;
               end
            end
            default: begin
               led_oe_nxt = 1'b1;
            end
         endcase
         if (wdog_trip_c) begin
            state_nxt  = IDLE;
            led_oe_nxt = 1'b1;
         end
      end

      busy_nxt = (state_nxt != IDLE);
   end

   // Registered outputs and captured latch payload.
   always_ff @(posedge i2s_clk) begin
      if (rst) begin
         cap_row     <= '0;
         cap_bri     <= '0;
         row_addr    <= '0;
         led_oe      <= 1'b1;
         busy        <= 1'b0;
         frame_start <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         cap_row     <= cap_row_nxt;
         cap_bri     <= cap_bri_nxt;
         row_addr    <= row_addr_nxt;
         led_oe      <= led_oe_nxt;
         busy        <= busy_nxt;
         frame_start <= frame_start_nxt;
         overrun     <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl: table of single-latch scans plus overrun, re-latch, reset and watchdog sequences.
module tb_led_scan_ctrl;

   localparam int unsigned ROW_W = 6;
`ifdef LED_SCAN_WATCHDOG_EN
   localparam int unsigned WDOG = 100;
`else
   localparam int unsigned WDOG = 65535;
`endif

   logic             i2s_clk;
   logic             rst;
   logic             lat_in;
   logic [ROW_W-1:0] row_in;
   logic [7:0]       brightness;
   logic [ROW_W-1:0] row_addr;
   logic             led_oe, busy, frame_start, overrun, stall;

   led_scan_ctrl #(
      .ROW_W(ROW_W), .BLANK_CYCLES(4), .SETTLE_CYCLES(2), .ON_MULT(4), .WDOG_CYCLES(WDOG)
   ) dut (
      .i2s_clk     (i2s_clk),
      .rst         (rst),
      .lat_in      (lat_in),
      .row_in      (row_in),
      .brightness  (brightness),
      .row_addr    (row_addr),
      .led_oe      (led_oe),
      .busy        (busy),
      .frame_start (frame_start),
      .overrun     (overrun),
      .stall       (stall)
   );

   initial i2s_clk = 1'b0;
   always #5 i2s_clk = ~i2s_clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [ROW_W-1:0] row;
      logic [7:0]       bri;
      int               exp_on;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i2s_clk);
      #1;
   endtask

   task automatic latch(input logic [ROW_W-1:0] r, input logic [7:0] b);
      lat_in     = 1'b1;
      row_in     = r;
      brightness = b;
      tick();
      lat_in     = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 2000) begin
         tick();
         n++;
      end
      chk(name, 32'(busy), 32'd0);
   endtask

   // Cycle k after the latch: BLANK 1..4, SETTLE 5..6, ON 7..6+exp_on, then IDLE.
   task automatic run_scenario(input logic [ROW_W-1:0] r, input logic [7:0] b,
                               input int exp_on, input logic [ROW_W-1:0] prev);
      int on_cnt = 0;
      latch(r, b);
      for (int k = 1; k <= 9 + exp_on; k++) begin
         if (k > 1) tick();
         chk("row_addr",    32'(row_addr),    32'((k >= 5) ? r : prev));
         chk("led_oe",      32'(led_oe),      (k >= 7 && k <= 6 + exp_on) ? 32'd0 : 32'd1);
         chk("busy",        32'(busy),        (k <= 6 + exp_on) ? 32'd1 : 32'd0);
         chk("frame_start", 32'(frame_start), (k == 1 && r == '0) ? 32'd1 : 32'd0);
         chk("overrun",     32'(overrun),     32'd0);
         chk("stall",       32'(stall),       32'd0);
         if (!led_oe) on_cnt++;
      end
      chk("on_cycles", 32'(on_cnt), 32'(exp_on));
   endtask

   initial begin
      vecs[0] = '{row: 6'd5,  bri: 8'd8, exp_on: 32};
      vecs[1] = '{row: 6'd0,  bri: 8'd8, exp_on: 32};
      vecs[2] = '{row: 6'd0,  bri: 8'd0, exp_on: 0};
      vecs[3] = '{row: 6'd63, bri: 8'd1, exp_on: 4};
`ifdef LED_SCAN_WATCHDOG_EN
      vecs[4] = '{row: 6'd17, bri: 8'd16, exp_on: 64};
`else
      vecs[4] = '{row: 6'd17, bri: 8'd255, exp_on: 1020};
`endif

      rst = 1'b1; lat_in = 1'b0; row_in = '0; brightness = '0;
      tick();
      tick();
      chk("rst_row_addr",    32'(row_addr),    32'd0);
      chk("rst_led_oe",      32'(led_oe),      32'd1);
      chk("rst_busy",        32'(busy),        32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
      chk("rst_overrun",     32'(overrun),     32'd0);
      chk("rst_stall",       32'(stall),       32'd0);
      rst = 1'b0;
      tick();

      begin
         logic [ROW_W-1:0] prev;
         prev = '0;
         for (int i = 0; i < 5; i++) begin
            run_scenario(vecs[i].row, vecs[i].bri, vecs[i].exp_on, prev);
            prev = vecs[i].row;
         end
      end

      // Second latch partway into ON truncates it.
      latch(6'd9, 8'd8);
      repeat (15) tick();
      chk("t3_on_before", 32'(led_oe), 32'd0);
      latch(6'd22, 8'd8);
      chk("t3_overrun",  32'(overrun),  32'd1);
      chk("t3_led_oe",   32'(led_oe),   32'd1);
      chk("t3_busy",     32'(busy),     32'd1);
      chk("t3_row_hold", 32'(row_addr), 32'd9);
      for (int j = 2; j <= 5; j++) begin
         tick();
         chk("t3_overrun_clr", 32'(overrun), 32'd0);
         chk("t3_row", 32'(row_addr), (j == 5) ? 32'd22 : 32'd9);
      end
      wait_idle("t3_idle");

      // Re-latch inside BLANK restarts blanking without overrun.
      latch(6'd11, 8'd8);
      tick();
      chk("t4_overrun_a", 32'(overrun), 32'd0);
      latch(6'd12, 8'd8);
      chk("t4_overrun_b", 32'(overrun), 32'd0);
      chk("t4_led_oe",    32'(led_oe),  32'd1);
      for (int j = 2; j <= 5; j++) begin
         tick();
         chk("t4_row", 32'(row_addr), (j == 5) ? 32'd12 : 32'd22);
         chk("t4_overrun", 32'(overrun), 32'd0);
      end
      wait_idle("t4_idle");
      chk("t4_final_row", 32'(row_addr), 32'd12);

      // Reset during ON blanks on the next edge.
      latch(6'd30, 8'd255);
      repeat (19) tick();
      chk("t5_on_before", 32'(led_oe), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_led_oe",   32'(led_oe),   32'd1);
      chk("t5_row_addr", 32'(row_addr), 32'd0);
      chk("t5_busy",     32'(busy),     32'd0);
      chk("t5_overrun",  32'(overrun),  32'd0);
      run_scenario(6'd3, 8'd2, 8, 6'd0);

`ifdef LED_SCAN_WATCHDOG_EN
      // Watchdog trips 100 cycles after reset with no latch.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (i == 99) chk("t6_stall_pre", 32'(stall), 32'd0);
      end
      chk("t6_stall",  32'(stall),  32'd1);
      chk("t6_led_oe", 32'(led_oe), 32'd1);
      chk("t6_busy",   32'(busy),   32'd0);
      repeat (5) tick();
      chk("t6_stall_sticky", 32'(stall), 32'd1);
      run_scenario(6'd7, 8'd3, 12, 6'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
Row-scan scheduler for the LED panel output stage. It sits after the I2S stream mask and sequences panel row changes. On each row-latch event it blanks the panel, drives the new row address, waits for settling, then enables the LEDs for an on-time set by a brightness value. It owns the output-enable and row-address pins, arbitrates between a running on-period and a new latch, and reports overruns.

Parameters:
ROW_W, 6, width of row address (matches 6-bit row number from the stream header)
BLANK_CYCLES, 4, cycles of forced blanking before the row address changes (≥1)
SETTLE_CYCLES, 2, cycles between the row address change and LED enable (≥1)
ON_MULT, 4, on-time cycles per brightness LSB (≥1)
WDOG_CYCLES, 65535, cycles without a latch before stall (only with the optional feature)

Ports:
i2s_clk  in  1  the only clock, shared with the stream mask
rst  in  1  synchronous, active-high reset
lat_in  in  1  one-cycle pulse: new row data has been latched into the column drivers
row_in  in  ROW_W  row number valid with lat_in
brightness  in  8  global dim level, sampled on lat_in; 0 means dark
row_addr  out  ROW_W  registered panel row address
led_oe  out  1  registered, active-low panel enable (1 = blanked)
busy  out  1  high in any state other than IDLE
frame_start  out  1  one-cycle pulse when the captured row_in is 0
overrun  out  1  one-cycle pulse when lat_in truncates SETTLE or ON
stall  out  1  watchdog flag (tied 0 when the feature is compiled out)

Behaviour:
- One clock and a synchronous active-high reset; the clock and reset are as stated in the Ports section.
- Reset values: row_addr=0, led_oe=1, busy=0, frame_start=0, overrun=0, stall=0, state=IDLE, counters=0. Reset applied mid-operation blanks the panel on the next edge.
- FSM states: IDLE, BLANK, SETTLE, ON.
- lat_in at edge N, from any state:
  - capture row_in and brightness;
  - load the timer with BLANK_CYCLES;
  - state=BLANK and led_oe=1 from N+1;
  - frame_start=1 at N+1 if the captured row is 0.
- BLANK: timer counts down. On expiry, row_addr is set to the captured row, the timer is loaded with SETTLE_CYCLES, and state becomes SETTLE. row_addr is first visible at N+1+BLANK_CYCLES.
- SETTLE: on expiry, if the captured brightness is 0, go to IDLE with led_oe kept at 1. Otherwise load the timer with brightness*ON_MULT and go to ON with led_oe=0.
- ON timer width is 8+clog2(ON_MULT) bits. The product must not truncate: 255*ON_MULT must fit.
- ON: led_oe=0 for exactly brightness*ON_MULT cycles, then led_oe=1 and state=IDLE.
- led_oe is low only in ON. It never falls in the same cycle row_addr changes.
- lat_in in SETTLE or ON: the period is truncated, overrun pulses at N+1, and the new latch is handled as above.
- lat_in in BLANK: blanking restarts with the new row, no overrun.
- lat_in in IDLE: normal start, no overrun.
- lat_in in the cycle ON expires: the latch takes priority and overrun pulses.
- row_addr holds its last value in IDLE.

Optional Feature:
LED_SCAN_WATCHDOG_EN
- Defined:
  - a counter resets on every lat_in; when it reaches WDOG_CYCLES it saturates;
  - stall=1 is sticky until the next lat_in or rst;
  - led_oe is forced to 1 while stall is high;
  - the FSM returns to IDLE.
- Undefined: the counter is absent and stall is tied to 0.

Decomposition:
- Package led_scan_pkg:
  - state enum (IDLE/BLANK/SETTLE/ON);
  - ON timer width function;
  - default constants for the timing parameters.
- Sub-module led_scan_timer: loadable down-counter with load, load value and expired outputs. One instance is reused for BLANK, SETTLE and ON.

Test Plan:
1. Defaults, brightness=8, lat_in with row_in=5 at N:
   - led_oe=1 over N+1..N+4;
   - row_addr=5 at N+5;
   - led_oe=0 over N+7..N+38 (32 cycles);
   - then IDLE with busy=0.
2. row_in=0:
   - frame_start high for exactly cycle N+1.
   - brightness=0: led_oe never low, IDLE after SETTLE.
3. Second lat_in 10 cycles into ON:
   - overrun pulse;
   - led_oe=1 next cycle;
   - row_addr unchanged for 4 cycles, then the new row.
4. lat_in twice, 2 cycles apart, within BLANK:
   - no overrun;
   - only the second row reaches row_addr.
5. rst asserted during ON (brightness=255):
   - next edge gives led_oe=1, row_addr=0, busy=0;
   - a lat_in after reset runs a normal sequence.
6. LED_SCAN_WATCHDOG_EN, WDOG_CYCLES=100, no lat_in:
   - stall=1 at cycle 100 and led_oe=1;
   - the next lat_in clears stall and runs a normal sequence.
